hex_scan_ctrl: RTL and testbench



---
 rtl/hex_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - multiplexed seven-segment scan controller with double-buffered value and per-slot blanking
// Optional build macro: HEX_SCAN_LZ_BLANK_EN enables leading-zero suppression of digits above digit 0.
module hex_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    load,
   output logic [3:0]              hexVal,
   output logic                    deci,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    pending,
   output logic                    frame_start
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]             cnt_q, cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   // run_q is low only until the first edge after reset; that edge starts frame 0 at cnt=0, idx=0.
   logic                      run_q, run_d;
   logic                      boundary;
   logic [4*NUM_DIGITS-1:0]   sh_val_q, sh_val_d;
   logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d;
   logic [4*NUM_DIGITS-1:0]   buf_val_q, buf_val_d;
   logic [NUM_DIGITS-1:0]     buf_dp_q, buf_dp_d;
   logic                      pend_q, pend_d;
   logic [3:0]                hex_q, hex_d;
   logic                      deci_q, deci_d;
   logic [NUM_DIGITS-1:0]     anode_q, anode_d;
   logic                      fs_q, fs_d;
   logic                      in_blank;

   // Blank phase decode from next-state counter; absent entirely when BLANK_CYCLES is zero.
   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
   end else begin : g_blank
      assign in_blank = (cnt_d < BLANK_END);
   end

   // Next-state: slot counter, digit index, frame boundary and double-buffered value capture.
   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      run_d     = 1'b1;
      boundary  = 1'b0;
      sh_val_d  = sh_val_q;
      sh_dp_d   = sh_dp_q;
      buf_val_d = buf_val_q;
      buf_dp_d  = buf_dp_q;
      pend_d    = pend_q;

      if (!run_q) begin
         cnt_d    = '0;
         idx_d    = '0;
         boundary = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      if (load) begin
         buf_val_d = value;
         buf_dp_d  = dp_mask;
      end

      if (boundary) begin
         pend_d = 1'b0;
         if (load) begin
            sh_val_d = value;
            sh_dp_d  = dp_mask;
         end else if (pend_q) begin
            sh_val_d = buf_val_q;
            sh_dp_d  = buf_dp_q;
         end
      end else if (load) begin
         pend_d = 1'b1;
      end
   end

   // Output decode from next-state so registered outputs line up with the state they describe.
   always_comb begin
      logic [NUM_DIGITS-1:0] onehot;
`ifdef HEX_SCAN_LZ_BLANK_EN
      logic [NUM_DIGITS-1:0] suppress;
      logic                  zero_run;
`endif
      onehot        = '0;
      onehot[idx_d] = 1'b1;
      anode_d       = in_blank ? '1 : ~onehot;
`ifdef HEX_SCAN_LZ_BLANK_EN
      suppress = '0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run    = zero_run && (sh_val_d[4*k +: 4] == 4'h0) && !sh_dp_d[k];
         suppress[k] = zero_run;
      end
      if (suppress[idx_d]) begin
         anode_d = '1;
      end
`endif
      hex_d  = sh_val_d[{idx_d, 2'b00} +: 4];
      deci_d = sh_dp_d[idx_d];
      fs_d   = (cnt_d == '0) && (idx_d == '0);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         run_q     <= 1'b0;
         sh_val_q  <= '0;
         sh_dp_q   <= '0;
         buf_val_q <= '0;
         buf_dp_q  <= '0;
         pend_q    <= 1'b0;
         hex_q     <= 4'h0;
         deci_q    <= 1'b0;
         anode_q   <= '1;
         fs_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         run_q     <= run_d;
         sh_val_q  <= sh_val_d;
         sh_dp_q   <= sh_dp_d;
         buf_val_q <= buf_val_d;
         buf_dp_q  <= buf_dp_d;
         pend_q    <= pend_d;
         hex_q     <= hex_d;
         deci_q    <= deci_d;
         anode_q   <= anode_d;
         fs_q      <= fs_d;
      end
   end

   assign hexVal      = hex_q;
   assign deci        = deci_q;
   assign anode       = anode_q;
   assign pending     = pend_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - directed-vector bench for hex_scan_ctrl (4 digits, 8 cycles/slot, 2 blank cycles)
module tb_hex_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = 16'h0;
   logic [3:0]  dp_mask = 4'h0;
   logic        load = 1'b0;
   logic [3:0]  hexVal;
   logic        deci;
   logic [3:0]  anode;
   logic        pending;
   logic        frame_start;

   int n_vec = 0;
   int n_err = 0;
   int cur_cyc = 0;

   hex_scan_ctrl #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp_mask    (dp_mask),
      .load       (load),
      .hexVal     (hexVal),
      .deci       (deci),
      .anode      (anode),
      .pending    (pending),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cur_cyc, got, exp);
      end
   endtask

   // Digits k>0 that leading-zero suppression would blank for a given shadow value.
   function automatic logic [3:0] lz_sup(input logic [15:0] v, input logic [3:0] d);
      logic [3:0] s;
      s = 4'b0000;
`ifdef HEX_SCAN_LZ_BLANK_EN
      if (v[15:12] == 4'h0 && !d[3]) s[3] = 1'b1;
      if (s[3] && v[11:8] == 4'h0 && !d[2]) s[2] = 1'b1;
      if (s[2] && v[7:4] == 4'h0 && !d[1]) s[1] = 1'b1;
`endif
      return s;
   endfunction

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_anode"}, 32'(anode), 32'hF);
      check_eq({tag, "_hex"}, 32'(hexVal), 32'h0);
      check_eq({tag, "_deci"}, 32'(deci), 32'h0);
      check_eq({tag, "_pend"}, 32'(pending), 32'h0);
      check_eq({tag, "_fs"}, 32'(frame_start), 32'h0);
   endtask

   // Reset, then run ncyc cycles from cycle 0 with up to two loads (la=-1 means load on the start edge),
   // checking every output against the expected shadow for frame 0 / frame 1.
   task automatic scenario(input string tag, input int ncyc,
                           input int la, input logic [15:0] va, input logic [3:0] da,
                           input int lb, input logic [15:0] vb, input logic [3:0] db,
                           input logic [15:0] f0v, input logic [3:0] f0d,
                           input logic [15:0] f1v, input logic [3:0] f1d,
                           input int pfrom, input int pto);
      logic [15:0] ev;
      logic [3:0]  ed, sup, ea, one;
      int          slot, ph;
      rst  = 1'b1;
      load = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cur_cyc = -1;
      check_reset_vals({tag, "_rst"});
      if (la < 0) begin
         load    = 1'b1;
         value   = va;
         dp_mask = da;
      end
      rst = 1'b0;
      @(negedge clk);
      for (int c = 0; c < ncyc; c++) begin
         cur_cyc = c;
         slot    = (c / 8) % 4;
         ph      = c % 8;
         ev      = (c < 32) ? f0v : f1v;
         ed      = (c < 32) ? f0d : f1d;
         sup     = lz_sup(ev, ed);
         one     = 4'b0001 << slot;
         ea      = (ph < 2 || sup[slot]) ? 4'hF : ~one;
         check_eq({tag, "_anode"}, 32'(anode), 32'(ea));
         check_eq({tag, "_hex"}, 32'(hexVal), 32'((ev >> (4 * slot)) & 16'hF));
         check_eq({tag, "_deci"}, 32'(deci), 32'((ed >> slot) & 4'h1));
         check_eq({tag, "_pend"}, 32'(pending), 32'(c >= pfrom && c <= pto));
         check_eq({tag, "_fs"}, 32'(frame_start), 32'(c % 32 == 0));
         load = 1'b0;
         if (c == la) begin
            load = 1'b1; value = va; dp_mask = da;
         end
         if (c == lb) begin
            load = 1'b1; value = vb; dp_mask = db;
         end
         @(negedge clk);
      end
      cur_cyc = ncyc;
      load = 1'b0;
   endtask

   initial begin
      // Plain scan plus one load mid frame 0: 1234 with dp on digit 2.
      scenario("ld1234", 64, 5, 16'h1234, 4'b0100, -5, 16'h0, 4'h0,
               16'h0000, 4'h0, 16'h1234, 4'b0100, 6, 31);
      // Two loads before the boundary: last write wins.
      scenario("lastwr", 64, 5, 16'hAAAA, 4'h0, 20, 16'hBEEF, 4'h0,
               16'h0000, 4'h0, 16'hBEEF, 4'h0, 6, 31);
      // Load on the boundary edge goes straight to shadow; pending never rises.
      scenario("bndld", 64, 31, 16'h5678, 4'h0, -5, 16'h0, 4'h0,
               16'h0000, 4'h0, 16'h5678, 4'h0, -1, -2);
      // Load pending when reset hits at cycle 45.
      scenario("prerst", 45, 40, 16'h9ABC, 4'b1111, -5, 16'h0, 4'h0,
               16'h0000, 4'h0, 16'h0000, 4'h0, 41, 44);
      check_eq("prerst_pend45", 32'(pending), 32'h1);
      rst = 1'b1;
      #1;
      cur_cyc = 45;
      check_reset_vals("midrst");
      // After reset the old load is gone and the frame restarts at idx 0.
      scenario("postrst", 64, -5, 16'h0, 4'h0, -5, 16'h0, 4'h0,
               16'h0000, 4'h0, 16'h0000, 4'h0, -1, -2);
      // Load coinciding with the start edge shows in the first frame; 0050 exercises leading-zero blanking.
      scenario("lz0050", 64, -1, 16'h0050, 4'h0, -5, 16'h0, 4'h0,
               16'h0050, 4'h0, 16'h0050, 4'h0, -1, -2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
